vga_paddle_ctrl: RTL and testbench

Parametrised paddle controller for the Breakout VGA path. It sits beside VGA_Sync and the colour mux. It debounces btnL/btnR, moves the paddle once per frame with accelerating speed and wall clamping, and produces a registered per-pixel bar hit (barWire) for the colour stage. Successor to the fixed-speed paddle: geometry, speed profile and debounce are all generics.

---
 rtl/vga_paddle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_vga_paddle_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_paddle_ctrl.sv
// Breakout paddle controller: debounced buttons, accelerating per-frame motion
// with wall clamping, and a registered per-pixel paddle hit for the colour stage.
module vga_paddle_ctrl #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned PADDLE_W        = 64,
  parameter int unsigned PADDLE_H        = 8,
  parameter int unsigned PADDLE_Y        = 456,
  parameter int unsigned MAX_SPEED       = 8,
  parameter int unsigned ACCEL_FRAMES    = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] pixelX,
  input  logic [9:0] pixelY,
  input  logic       btnL,
  input  logic       btnR,
  output logic       barWire,
  output logic [9:0] paddleX,
  output logic [3:0] speed,
  output logic       atWall
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned AW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic signed [10:0] X_MAX   = 11'(H_ACTIVE - PADDLE_W);
  localparam logic [9:0]         X_RESET = 10'((H_ACTIVE - PADDLE_W) / 2);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_t;

  logic [1:0]    sync1, sync2, deb;
  logic [CW-1:0] cnt [2];
  logic          hit_q, strobe_q;
  state_t        state, state_n;
  dir_t          dir_c, dir_q;
  logic [AW-1:0] fc, fc_n;
  logic [3:0]    spd_n;
  logic [9:0]    pos_n;
  logic          clamp_c;
  logic signed [10:0] base_c, step_c, sum_c;

  // Bit 0 is the left button, bit 1 the right button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= {btnR, btnL};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    dir_c = DIR_NONE;
    case (deb)
      2'b01:   dir_c = DIR_L;
      2'b10:   dir_c = DIR_R;
      default: dir_c = DIR_NONE;
    endcase
  end

  // One strobe per frame on the rising edge of the pixelY == V_ACTIVE condition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      hit_q    <= (pixelY == 10'(V_ACTIVE));
      strobe_q <= (pixelY == 10'(V_ACTIVE)) && !hit_q;
    end
  end

  // Speed profile and clamped position for the coming strobe.
  always_comb begin
    state_n = state;
    spd_n   = speed;
    fc_n    = fc;
    if (dir_c == DIR_NONE) begin
      state_n = IDLE;
      spd_n   = 4'd0;
      fc_n    = '0;
    end else if (state == IDLE || dir_c != dir_q) begin
      state_n = (MAX_SPEED == 1) ? CRUISE : ACCEL;
      spd_n   = 4'd1;
      fc_n    = '0;
    end else if (state == ACCEL) begin
      if (fc == AW'(ACCEL_FRAMES - 1)) begin
        spd_n = speed + 4'd1;
        fc_n  = '0;
        if (spd_n == 4'(MAX_SPEED)) state_n = CRUISE;
      end else begin
        fc_n = fc + AW'(1);
      end
    end else begin
      spd_n = 4'(MAX_SPEED);
    end

    base_c  = $signed({1'b0, paddleX});
    step_c  = $signed({7'b0, spd_n});
    sum_c   = (dir_c == DIR_L) ? (base_c - step_c) : (base_c + step_c);
    clamp_c = (dir_c != DIR_NONE) && ((sum_c < 11'sd0) || (sum_c > X_MAX));
    if (dir_c == DIR_NONE)  pos_n = paddleX;
    else if (sum_c < 11'sd0) pos_n = 10'd0;
    else if (sum_c > X_MAX)  pos_n = X_MAX[9:0];
    else                     pos_n = sum_c[9:0];

    // A clamp while moving parks the paddle; a clamp on the restart keeps speed 1.
    if (clamp_c && state != IDLE) begin
      state_n = IDLE;
      spd_n   = 4'd0;
      fc_n    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dir_q   <= DIR_NONE;
      fc      <= '0;
      speed   <= 4'd0;
      paddleX <= X_RESET;
      atWall  <= 1'b0;
    end else begin
      atWall <= 1'b0;
      if (strobe_q) begin
        state   <= state_n;
        dir_q   <= dir_c;
        fc      <= fc_n;
        speed   <= spd_n;
        paddleX <= pos_n;
        atWall  <= clamp_c;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      barWire <= 1'b0;
    end else begin
      barWire <= ({1'b0, pixelX} >= {1'b0, paddleX}) &&
                 ({1'b0, pixelX} <  ({1'b0, paddleX} + 11'(PADDLE_W))) &&
                 ({1'b0, pixelY} >= 11'(PADDLE_Y)) &&
                 ({1'b0, pixelY} <  11'(PADDLE_Y + PADDLE_H));
    end
  end

endmodule

// File: tb/tb_vga_paddle_ctrl.sv
// Self-checking bench for vga_paddle_ctrl: per-cycle frame-level model plus
// directed literal expectations, using compressed frames.
module tb_vga_paddle_ctrl;

  localparam int D_CYC = 4;
  localparam int AF    = 2;
  localparam int MAXS  = 4;
  localparam int VACT  = 480;
  localparam int PW    = 64;
  localparam int PH    = 8;
  localparam int PY    = 456;
  localparam int XMAX  = 640 - PW;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] pixelX = '0;
  logic [9:0] pixelY = '0;
  logic       btnL = 1'b0;
  logic       btnR = 1'b0;
  logic       barWire;
  logic [9:0] paddleX;
  logic [3:0] speed;
  logic       atWall;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;
  int wall_cnt = 0;

  vga_paddle_ctrl #(
    .MAX_SPEED(MAXS), .ACCEL_FRAMES(AF), .DEBOUNCE_CYCLES(D_CYC)
  ) dut (
    .clock(clock), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .btnL(btnL), .btnR(btnR), .barWire(barWire), .paddleX(paddleX),
    .speed(speed), .atWall(atWall)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level model: speed = min(1 + held_frames/AF, MAXS), position clamped to [0, XMAX].
  int m_pos, m_spd, m_run, m_dir_last;
  bit m_wall, m_bar, m_hit_q, m_stb;
  bit m_sync [2][2];
  bit m_deb [2];
  int m_diff [2];

  always @(posedge clock or negedge reset) begin
    int  dir, target;
    bit  moving;
    bit  raw [2];
    if (!reset) begin
      m_pos = (640 - PW) / 2; m_spd = 0; m_run = 0; m_dir_last = 0;
      m_wall = 0; m_bar = 0; m_hit_q = 0; m_stb = 0;
      for (int i = 0; i < 2; i++) begin
        m_sync[i][0] = 0; m_sync[i][1] = 0; m_deb[i] = 0; m_diff[i] = 0;
      end
    end else begin
      raw[0] = btnL;
      raw[1] = btnR;
      m_bar = (int'(pixelX) >= m_pos) && (int'(pixelX) < m_pos + PW) &&
              (int'(pixelY) >= PY) && (int'(pixelY) < PY + PH);
      m_wall = 0;
      if (m_stb) begin
        dir = (m_deb[0] && !m_deb[1]) ? -1 : (m_deb[1] && !m_deb[0]) ? 1 : 0;
        if (dir == 0) begin
          m_spd = 0; m_run = 0;
        end else begin
          moving = (m_spd != 0);
          if (!moving || dir != m_dir_last) m_run = 0;
          else m_run++;
          m_spd = (1 + m_run / AF > MAXS) ? MAXS : 1 + m_run / AF;
          target = m_pos + dir * m_spd;
          if (target < 0 || target > XMAX) begin
            m_pos  = (target < 0) ? 0 : XMAX;
            m_wall = 1;
            if (moving) begin m_spd = 0; m_run = 0; end
          end else begin
            m_pos = target;
          end
        end
        m_dir_last = dir;
      end
      m_stb   = (int'(pixelY) == VACT) && !m_hit_q;
      m_hit_q = (int'(pixelY) == VACT);
      // Debounced level flips after D_CYC consecutive synchronised disagreements.
      for (int i = 0; i < 2; i++) begin
        if (m_sync[i][1] != m_deb[i]) begin
          m_diff[i]++;
          if (m_diff[i] == D_CYC) begin m_deb[i] = m_sync[i][1]; m_diff[i] = 0; end
        end else begin
          m_diff[i] = 0;
        end
        m_sync[i][1] = m_sync[i][0];
        m_sync[i][0] = raw[i];
      end
    end
  end

  always @(negedge clock) begin
    if (reset && cmp_en) begin
      check("paddleX", paddleX, m_pos);
      check("speed", speed, m_spd);
      check("atWall", atWall, m_wall);
      check("barWire", barWire, m_bar);
      if (atWall) wall_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic frame();
    pixelY = 10'd10;  tick(3);
    pixelY = 10'(VACT); tick(3);
    pixelY = 10'd10;  tick(3);
  endtask

  task automatic bar_at(input int x, input int y, input int exp);
    pixelX = 10'(x); pixelY = 10'(y);
    tick(1);
    check("bar_literal", barWire, exp);
  endtask

  int exp_spd [8] = '{1, 1, 2, 2, 3, 3, 4, 4};
  int exp_pos [8] = '{289, 290, 292, 294, 297, 300, 304, 308};

  initial begin
    int k, base;
    tick(3);
    check("rst_paddleX", paddleX, 288);
    check("rst_speed", speed, 0);
    check("rst_barWire", barWire, 0);
    check("rst_atWall", atWall, 0);
    reset = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    repeat (3) frame();
    check("idle_paddleX", paddleX, 288);
    check("idle_speed", speed, 0);

    for (int y = 454; y <= 465; y++)
      for (int x = 284; x <= 356; x++) begin
        pixelX = 10'(x); pixelY = 10'(y); tick(1);
      end
    bar_at(288, 456, 1);
    bar_at(287, 456, 0);
    bar_at(351, 463, 1);
    bar_at(352, 460, 0);
    bar_at(300, 455, 0);
    bar_at(300, 464, 0);
    pixelX = '0; pixelY = 10'd10; tick(1);

    btnR = 1'b1; tick(3); btnR = 1'b0;
    tick(10);
    frame();
    check("glitch_paddleX", paddleX, 288);
    check("glitch_speed", speed, 0);

    btnR = 1'b1; tick(10);
    for (int f = 0; f < 8; f++) begin
      frame();
      check("ramp_speed", speed, exp_spd[f]);
      check("ramp_paddleX", paddleX, exp_pos[f]);
    end

    btnL = 1'b1; tick(10); frame();
    check("both_speed", speed, 0);
    check("both_paddleX", paddleX, 308);
    btnR = 1'b0; tick(10);
    frame(); check("left_speed1", speed, 1); check("left_pos1", paddleX, 307);
    frame(); check("left_speed2", speed, 1); check("left_pos2", paddleX, 306);
    frame(); check("left_speed3", speed, 2); check("left_pos3", paddleX, 304);
    btnL = 1'b0; btnR = 1'b1; tick(10);
    frame(); check("switch_speed", speed, 1); check("switch_pos", paddleX, 305);

    btnR = 1'b0; btnL = 1'b1; tick(10);
    base = wall_cnt; k = 0;
    while (wall_cnt == base && k < 150) begin frame(); k++; end
    check("wall_first_pulse", wall_cnt - base, 1);
    check("wall_paddleX", paddleX, 0);
    check("wall_speed", speed, 0);
    frame();
    check("wall_restart_speed", speed, 1);
    check("wall_restart_pos", paddleX, 0);
    check("wall_second_pulse", wall_cnt - base, 2);
    frame();
    check("wall_third_speed", speed, 0);
    check("wall_third_pulse", wall_cnt - base, 3);

    btnL = 1'b0; btnR = 1'b1; tick(10);
    k = 0;
    while (paddleX != 10'd400 && k < 150) begin frame(); k++; end
    check("cruise_paddleX", paddleX, 400);
    check("cruise_speed", speed, 4);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("async_rst_paddleX", paddleX, 288);
    check("async_rst_speed", speed, 0);
    check("async_rst_barWire", barWire, 0);
    tick(2);
    reset = 1'b1;
    tick(10);
    frame();
    check("post_rst_speed", speed, 1);
    check("post_rst_paddleX", paddleX, 289);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
